// File: rtl/axi_master_wresp_tracker.sv
// ============================================================================
// axi_master_wresp_tracker : AXI write-response tracker (in-order ID FIFO,
// WLAST counting, BID check). Optional watchdog: define WRESP_TIMEOUT_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module axi_master_wresp_tracker #(
  parameter int ID_W           = 12,
  parameter int MAX_OUT        = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic            clk,
  input  logic            m_axi_aresetn,
  input  logic            m_axi_awvalid,
  input  logic            m_axi_awready,
  input  logic [ID_W-1:0] m_axi_awid,
  input  logic            m_axi_wvalid,
  input  logic            m_axi_wready,
  input  logic            m_axi_wlast,
  input  logic            m_axi_bvalid,
  input  logic [ID_W-1:0] m_axi_bid,
  input  logic [1:0]      m_axi_bresp,
  output logic            m_axi_bready,
  input  logic            bready,
  output logic            aw_stall,
  output logic            tx_bwait,
  output logic            wresp_valid,
  output logic [ID_W-1:0] wresp_id,
  output logic [1:0]      wresp_code,
  output logic            wresp_err,
  output logic            wresp_timeout
);

  localparam int PTR_W = $clog2(MAX_OUT);
  localparam int CNT_W = $clog2(MAX_OUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUT);

  if (MAX_OUT < 2 || (MAX_OUT & (MAX_OUT - 1)) != 0 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("axi_master_wresp_tracker: bad MAX_OUT or TIMEOUT_CYCLES");
  end

  logic [ID_W-1:0]  id_fifo [MAX_OUT];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] occ;
  logic [CNT_W-1:0] occ_next;
  logic [CNT_W-1:0] wdone;
  logic [CNT_W-1:0] wdone_next;
  logic             aw_hs;
  logic             wl_hs;
  logic             b_hs;
  logic             fifo_full;
  logic             push;
  logic             aw_ovf;
  logic             wl_ovf;
  logic             id_mismatch;

  assign m_axi_bready = bready & (occ != '0) & (wdone != '0);

  always_comb begin
    aw_hs       = m_axi_awvalid & m_axi_awready;
    wl_hs       = m_axi_wvalid & m_axi_wready & m_axi_wlast;
    b_hs        = m_axi_bvalid & m_axi_bready;
    fifo_full   = (occ == CNT_MAX);
    // A pop in the same cycle frees the slot, so a push at full is still accepted.
    push        = aw_hs & (~fifo_full | b_hs);
    aw_ovf      = aw_hs & fifo_full & ~b_hs;
    id_mismatch = b_hs & (m_axi_bid != id_fifo[rd_ptr]);

    occ_next = occ;
    if (push && !b_hs) begin
      occ_next = occ + CNT_W'(1);
    end else if (!push && b_hs) begin
      occ_next = occ - CNT_W'(1);
    end

    wdone_next = wdone;
    wl_ovf     = 1'b0;
    if (wl_hs && !b_hs) begin
      if (wdone == CNT_MAX) begin
        wl_ovf = 1'b1;
      end else begin
        wdone_next = wdone + CNT_W'(1);
      end
    end else if (!wl_hs && b_hs) begin
      wdone_next = wdone - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      id_fifo[wr_ptr] <= m_axi_awid;
    end
  end

  always_ff @(posedge clk) begin
    if (!m_axi_aresetn) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      occ         <= '0;
      wdone       <= '0;
      aw_stall    <= 1'b0;
      tx_bwait    <= 1'b0;
      wresp_valid <= 1'b0;
      wresp_id    <= '0;
      wresp_code  <= 2'b00;
      wresp_err   <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (b_hs) begin
        rd_ptr     <= rd_ptr + PTR_W'(1);
        wresp_id   <= m_axi_bid;
        wresp_code <= m_axi_bresp;
      end
      occ         <= occ_next;
      wdone       <= wdone_next;
      aw_stall    <= (occ_next == CNT_MAX);
      tx_bwait    <= (occ_next != '0);
      wresp_valid <= b_hs;
      // SLVERR/DECERR travel in wresp_code only; the flag is for protocol faults.
      if (aw_ovf || wl_ovf || id_mismatch) begin
        wresp_err <= 1'b1;
      end
    end
  end

`ifdef WRESP_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYCLES);

  logic [TO_W-1:0] to_cnt;
  logic            to_flag;

  always_ff @(posedge clk) begin
    if (!m_axi_aresetn) begin
      to_cnt  <= '0;
      to_flag <= 1'b0;
    end else begin
      if (b_hs || occ == '0) begin
        to_cnt <= '0;
      end else if (to_cnt != TO_MAX) begin
        to_cnt <= to_cnt + TO_W'(1);
      end
      if (to_cnt == TO_MAX) begin
        to_flag <= 1'b1;
      end
    end
  end

  assign wresp_timeout = to_flag;
`else
  assign wresp_timeout = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_axi_master_wresp_tracker.sv
// ============================================================================
// tb_axi_master_wresp_tracker : directed self-checking bench for the tracker.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_axi_master_wresp_tracker;

  localparam int ID_W = 12;

  logic            clk = 1'b0;
  logic            aresetn;
  logic            awvalid, awready, wvalid, wready, wlast, bvalid, bready;
  logic [ID_W-1:0] awid, bid;
  logic [1:0]      bresp;
  logic            m_bready, aw_stall, tx_bwait, wresp_valid, wresp_err, wresp_timeout;
  logic [ID_W-1:0] wresp_id;
  logic [1:0]      wresp_code;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  axi_master_wresp_tracker #(.ID_W(ID_W), .MAX_OUT(4), .TIMEOUT_CYCLES(255)) dut (
    .clk           (clk),
    .m_axi_aresetn (aresetn),
    .m_axi_awvalid (awvalid),
    .m_axi_awready (awready),
    .m_axi_awid    (awid),
    .m_axi_wvalid  (wvalid),
    .m_axi_wready  (wready),
    .m_axi_wlast   (wlast),
    .m_axi_bvalid  (bvalid),
    .m_axi_bid     (bid),
    .m_axi_bresp   (bresp),
    .m_axi_bready  (m_bready),
    .bready        (bready),
    .aw_stall      (aw_stall),
    .tx_bwait      (tx_bwait),
    .wresp_valid   (wresp_valid),
    .wresp_id      (wresp_id),
    .wresp_code    (wresp_code),
    .wresp_err     (wresp_err),
    .wresp_timeout (wresp_timeout)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    awvalid = 0; awready = 1; awid = '0;
    wvalid = 0; wready = 1; wlast = 0;
    bvalid = 0; bid = '0; bresp = 2'b00; bready = 1;
  endtask

  task automatic do_reset();
    aresetn = 0;
    idle_inputs();
    cycle();
    cycle();
    aresetn = 1;
  endtask

  initial begin
    do_reset();
    check("rst_wresp_valid", 32'(wresp_valid), 0);
    check("rst_tx_bwait", 32'(tx_bwait), 0);
    check("rst_aw_stall", 32'(aw_stall), 0);
    check("rst_wresp_err", 32'(wresp_err), 0);
    check("rst_wresp_timeout", 32'(wresp_timeout), 0);
    check("rst_wresp_id", 32'(wresp_id), 0);
    check("rst_m_bready", 32'(m_bready), 0);

    // Single burst, id 0x005
    awvalid = 1; awid = 12'h005;
    cycle();
    awvalid = 0;
    check("t1_tx_bwait_set", 32'(tx_bwait), 1);
    #1;
    check("t1_bready_no_wlast", 32'(m_bready), 0);
    wvalid = 1; wlast = 1;
    cycle();
    wvalid = 0; wlast = 0;
    bvalid = 1; bid = 12'h005; bresp = 2'b00;
    #1;
    check("t1_bready_ready", 32'(m_bready), 1);
    cycle();
    bvalid = 0;
    check("t1_wresp_valid", 32'(wresp_valid), 1);
    check("t1_wresp_id", 32'(wresp_id), 32'h005);
    check("t1_wresp_code", 32'(wresp_code), 0);
    check("t1_tx_bwait_clr", 32'(tx_bwait), 0);
    check("t1_wresp_err", 32'(wresp_err), 0);
    cycle();
    check("t1_valid_pulse", 32'(wresp_valid), 0);

    // WLAST before AW, bvalid held meanwhile
    wvalid = 1; wlast = 1;
    cycle();
    wvalid = 0; wlast = 0;
    bvalid = 1; bid = 12'h007;
    #1;
    check("t2_bready_no_aw_a", 32'(m_bready), 0);
    cycle();
    check("t2_bready_no_aw_b", 32'(m_bready), 0);
    check("t2_no_resp", 32'(wresp_valid), 0);
    awvalid = 1; awid = 12'h007;
    #1;
    check("t2_bready_aw_cycle", 32'(m_bready), 0);
    cycle();
    awvalid = 0;
    #1;
    check("t2_bready_after_aw", 32'(m_bready), 1);
    cycle();
    bvalid = 0;
    check("t2_wresp_valid", 32'(wresp_valid), 1);
    check("t2_wresp_id", 32'(wresp_id), 32'h007);

    // Fill FIFO with ids 1..4, each with its WLAST
    for (int k = 1; k <= 4; k++) begin
      awvalid = 1; awid = ID_W'(k); wvalid = 1; wlast = 1;
      cycle();
    end
    wvalid = 0; wlast = 0;
    awid = 12'h005;
    check("t3_aw_stall_full", 32'(aw_stall), 1);
    check("t3_tx_bwait_full", 32'(tx_bwait), 1);
    // Pop id 1 and push id 5 together
    bvalid = 1; bid = 12'h001;
    cycle();
    awvalid = 0;
    check("t3_resp1_id", 32'(wresp_id), 32'h001);
    check("t3_stall_kept", 32'(aw_stall), 1);
    check("t3_no_err_push_pop", 32'(wresp_err), 0);
    for (int k = 2; k <= 5; k++) begin
      bid = ID_W'(k);
      wvalid = (k == 2); wlast = (k == 2);
      cycle();
      check($sformatf("t3_resp%0d_valid", k), 32'(wresp_valid), 1);
      check($sformatf("t3_resp%0d_id", k), 32'(wresp_id), 32'(k));
    end
    bvalid = 0; wvalid = 0; wlast = 0;
    check("t3_drained_bwait", 32'(tx_bwait), 0);
    check("t3_drained_stall", 32'(aw_stall), 0);
    check("t3_err_clear", 32'(wresp_err), 0);

    // SLVERR reported without raising the error flag
    awvalid = 1; awid = 12'h003; wvalid = 1; wlast = 1;
    cycle();
    awvalid = 0; wvalid = 0; wlast = 0;
    bvalid = 1; bid = 12'h003; bresp = 2'b10;
    cycle();
    bvalid = 0; bresp = 2'b00;
    check("t4_code_slverr", 32'(wresp_code), 2);
    check("t4_err_clear", 32'(wresp_err), 0);

    // BID mismatch
    awvalid = 1; awid = 12'h00A; wvalid = 1; wlast = 1;
    cycle();
    awvalid = 0; wvalid = 0; wlast = 0;
    bvalid = 1; bid = 12'h00B;
    cycle();
    bvalid = 0;
    check("t5_resp_valid", 32'(wresp_valid), 1);
    check("t5_resp_id", 32'(wresp_id), 32'h00B);
    check("t5_err_set", 32'(wresp_err), 1);
    check("t5_entry_popped", 32'(tx_bwait), 0);
    cycle();
    cycle();
    check("t5_err_sticky", 32'(wresp_err), 1);

    // Reset with two outstanding
    awvalid = 1; awid = 12'h001;
    cycle();
    awid = 12'h002;
    cycle();
    awvalid = 0;
    check("t6_bwait_pre", 32'(tx_bwait), 1);
    aresetn = 0;
    cycle();
    aresetn = 1;
    check("t6_bwait_rst", 32'(tx_bwait), 0);
    check("t6_stall_rst", 32'(aw_stall), 0);
    check("t6_err_rst", 32'(wresp_err), 0);
    bvalid = 1; bid = 12'h001;
    #1;
    check("t6_bready_empty", 32'(m_bready), 0);
    bvalid = 0;

    // AW overflow at full without a pop
    for (int k = 1; k <= 4; k++) begin
      awvalid = 1; awid = ID_W'(k);
      cycle();
    end
    check("t7_err_before_ovf", 32'(wresp_err), 0);
    awid = 12'h009;
    cycle();
    awvalid = 0;
    check("t7_err_ovf", 32'(wresp_err), 1);
    check("t7_still_full", 32'(aw_stall), 1);

`ifdef WRESP_TIMEOUT_EN
    do_reset();
    awvalid = 1; awid = 12'h001;
    cycle();
    awvalid = 0;
    repeat (250) cycle();
    check("t8_timeout_early", 32'(wresp_timeout), 0);
    repeat (6) cycle();
    check("t8_timeout_set", 32'(wresp_timeout), 1);
`else
    repeat (300) cycle();
    check("t8_timeout_tied", 32'(wresp_timeout), 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
